// File: rtl/bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_ctrl
//  Description : Bus controller behind the core load/store port.
//                - CE[7:4] slaves are zero-wait: combinational pass-through,
//                  granted in the request cycle (only while the FSM is idle).
//                - CE[3:0] slaves use a request/acknowledge handshake with
//                  latched address/data and a per-access timeout, so the core
//                  can never hang on a dead slave.
//                - Multiple CE[3:0] bits set is an illegal access and
//                  completes at once with an error and no slave strobe.
//  Ports       : i_CLK/i_RST        clock, asynchronous active-high reset
//                i_REQ/i_CE/i_ADDR/i_WDATA/i_WE/i_HB   core request
//                o_GNT/o_RDATA      grant and read data to the core
//                o_SLV_*            slave select, address, data, controls
//                i_SLV_ACK/i_SLV_RDATA  slave acknowledge and read data
//                o_BUS_ERR/o_ERR_ADDR   error pulse and last error address
//  Revision    : 1.0  initial release
// ============================================================================
module bus_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic         i_CLK,
    input  logic         i_RST,
    input  logic         i_REQ,
    input  logic [7:0]   i_CE,
    input  logic [31:0]  i_ADDR,
    input  logic [31:0]  i_WDATA,
    input  logic         i_WE,
    input  logic [1:0]   i_HB,
    output logic         o_GNT,
    output logic [31:0]  o_RDATA,
    output logic [7:0]   o_SLV_CS,
    output logic [31:0]  o_SLV_ADDR,
    output logic [31:0]  o_SLV_WDATA,
    output logic         o_SLV_WE,
    output logic [1:0]   o_SLV_HB,
    input  logic [7:0]   i_SLV_ACK,
    input  logic [255:0] i_SLV_RDATA,
    output logic         o_BUS_ERR,
    output logic [31:0]  o_ERR_ADDR
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = {c_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic                r_we;
    logic [1:0]          r_hb;
    logic [3:0]          r_cs;
    logic [31:0]         r_rdata;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_err;
    logic [31:0]         r_err_addr;

    logic [3:0]          w_ce_lo;
    logic                w_wait_req;
    logic                w_multi;
    logic                w_ack_hit;
    logic                w_cnt_last;
    logic [31:0]         w_sel_rdata;
    logic [31:0]         w_fast_rdata;
    logic                w_unused;

    assign w_ce_lo    = i_CE[3:0];
    assign w_wait_req = i_REQ & (|w_ce_lo);
    // x & (x-1) clears the lowest set bit; anything left means >1 bit set.
    assign w_multi    = |(w_ce_lo & (w_ce_lo - 4'd1));
    assign w_ack_hit  = |(i_SLV_ACK[3:0] & r_cs);
    assign w_cnt_last = (r_cnt == c_CNT_LAST);

    // Zero-wait slaves never acknowledge and wait-state slots 4..7 do not exist.
    assign w_unused   = ^{i_SLV_ACK[7:4]};

    // Read slot of the latched (one-hot) wait-state slave.
    always_comb begin
        w_sel_rdata = '0;
        for (int n = 0; n < 4; n++) begin
            w_sel_rdata = w_sel_rdata | (i_SLV_RDATA[32*n +: 32] & {32{r_cs[n]}});
        end
    end

    // Read slot of the lowest set bit in CE[7:4]; iterating downwards lets the
    // lowest bit win.
    always_comb begin
        w_fast_rdata = '0;
        for (int n = 7; n >= 4; n--) begin
            if (i_CE[n]) begin
                w_fast_rdata = i_SLV_RDATA[32*n +: 32];
            end
        end
    end

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and core/slave outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        o_GNT       = 1'b0;
        o_RDATA     = '0;
        o_SLV_CS    = '0;
        o_SLV_ADDR  = '0;
        o_SLV_WDATA = '0;
        o_SLV_WE    = 1'b0;
        o_SLV_HB    = '0;
        o_BUS_ERR   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_wait_req) begin
                    // Illegal multi-select skips the slave phase entirely.
                    w_state_nxt = w_multi ? S_DONE : S_ACCESS;
                end else begin
                    o_GNT = 1'b1;
                    if (i_REQ) begin
                        o_SLV_CS    = i_CE;
                        o_SLV_ADDR  = i_ADDR;
                        o_SLV_WDATA = i_WDATA;
                        o_SLV_WE    = i_WE;
                        o_SLV_HB    = i_HB;
                        o_RDATA     = w_fast_rdata;
                    end
                end
            end
            S_ACCESS: begin
                o_SLV_CS    = {4'b0000, r_cs};
                o_SLV_ADDR  = r_addr;
                o_SLV_WDATA = r_wdata;
                o_SLV_WE    = r_we;
                o_SLV_HB    = r_hb;
                if (w_ack_hit || w_cnt_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_GNT       = 1'b1;
                o_RDATA     = r_rdata;
                o_BUS_ERR   = r_err;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Access latches, timeout counter, completion data and error capture
    // ------------------------------------------------------------------------
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_we       <= 1'b0;
            r_hb       <= '0;
            r_cs       <= '0;
            r_rdata    <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wait_req) begin
                        r_addr <= i_ADDR;
                        if (w_multi) begin
                            r_cs       <= '0;
                            r_rdata    <= '0;
                            r_err      <= 1'b1;
                            r_err_addr <= i_ADDR;
                        end else begin
                            r_wdata <= i_WDATA;
                            r_we    <= i_WE;
                            r_hb    <= i_HB;
                            r_cs    <= w_ce_lo;
                            r_cnt   <= '0;
                            r_err   <= 1'b0;
                        end
                    end
                end
                S_ACCESS: begin
                    // Ack takes priority over an expiring timeout.
                    if (w_ack_hit) begin
                        r_rdata <= w_sel_rdata;
                        r_err   <= 1'b0;
                    end else if (w_cnt_last) begin
                        r_rdata    <= '0;
                        r_err      <= 1'b1;
                        r_err_addr <= r_addr;
                    end else if (r_cnt != c_CNT_MAX) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_err <= 1'b0;
                    r_cs  <= '0;
                end
                default: begin
                    r_err <= 1'b0;
                end
            endcase
        end
    end

    assign o_ERR_ADDR = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_bus_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bus_ctrl
//  Description : Self-checking bench for bus_ctrl: a table of zero-wait
//                vectors, directed multi-cycle sequences (wait read, held
//                write, timeout, ack-on-last-count, illegal CE, reset during
//                an access) and randomized transactions checked against a
//                transaction-level model of grant cycle, data and error.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_ctrl;

    localparam int TIMEOUT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req;
    logic [7:0]   ce;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic         we;
    logic [1:0]   hb;
    logic         gnt;
    logic [31:0]  rdata;
    logic [7:0]   slv_cs;
    logic [31:0]  slv_addr;
    logic [31:0]  slv_wdata;
    logic         slv_we;
    logic [1:0]   slv_hb;
    logic [7:0]   slv_ack;
    logic [255:0] slv_rdata;
    logic         bus_err;
    logic [31:0]  err_addr;

    logic [31:0]  slots [8];
    logic [31:0]  model_err_addr;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            slv_rdata[32*n +: 32] = slots[n];
        end
    end

    bus_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .i_CLK       (clk),
        .i_RST       (rst),
        .i_REQ       (req),
        .i_CE        (ce),
        .i_ADDR      (addr),
        .i_WDATA     (wdata),
        .i_WE        (we),
        .i_HB        (hb),
        .o_GNT       (gnt),
        .o_RDATA     (rdata),
        .o_SLV_CS    (slv_cs),
        .o_SLV_ADDR  (slv_addr),
        .o_SLV_WDATA (slv_wdata),
        .o_SLV_WE    (slv_we),
        .o_SLV_HB    (slv_hb),
        .i_SLV_ACK   (slv_ack),
        .i_SLV_RDATA (slv_rdata),
        .o_BUS_ERR   (bus_err),
        .o_ERR_ADDR  (err_addr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Zero-wait read data: slot of the lowest set bit in CE[7:4], else 0.
    function automatic logic [31:0] fast_expect(input logic [7:0] c);
        for (int n = 4; n < 8; n++) begin
            if (c[n]) return slots[n];
        end
        return 32'h0;
    endfunction

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One zero-wait access; granted in the request cycle.
    task automatic run_fast(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [1:0] h);
        req = 1'b1; ce = c; addr = a; wdata = d; we = w; hb = h;
        slv_ack = 8'($urandom);
        #1;
        chk("fast_gnt",   32'(gnt), 32'h1);
        chk("fast_cs",    32'(slv_cs), 32'(c));
        chk("fast_rdata", rdata, fast_expect(c));
        chk("fast_addr",  slv_addr, a);
        chk("fast_wdata", slv_wdata, d);
        chk("fast_we_hb", 32'({slv_we, slv_hb}), 32'({w, h}));
        chk("fast_err",   32'(bus_err), 32'h0);
        tick();
    endtask

    // One wait-state (or illegal) access. The model decides the grant cycle:
    // illegal -> 1, ack after 'dly' access cycles (dly < TIMEOUT) -> dly+2,
    // no ack -> TIMEOUT+1. 'spur' are acks injected from non-selected slaves.
    task automatic run_wait(input logic [7:0] c, input logic [31:0] a, input logic [31:0] d,
                            input logic w, input logic [1:0] h, input int dly,
                            input bit wiggle, input logic [7:0] spur);
        logic [3:0]  lo;
        int          sel;
        int          g;
        bit          illegal;
        bit          exp_err;
        logic [31:0] exp_rd;
        logic [7:0]  one;
        lo      = c[3:0];
        illegal = ($countones(lo) > 1);
        sel     = 0;
        for (int n = 3; n >= 0; n--) if (lo[n]) sel = n;
        one = 8'd1 << sel;
        if (illegal) begin
            g = 1; exp_rd = 32'h0; exp_err = 1'b1;
        end else if (dly < TIMEOUT) begin
            g = dly + 2; exp_rd = slots[sel]; exp_err = 1'b0;
        end else begin
            g = TIMEOUT + 1; exp_rd = 32'h0; exp_err = 1'b1;
        end
        if (exp_err) model_err_addr = a;

        req = 1'b1; ce = c; addr = a; wdata = d; we = w; hb = h;
        for (int cyc = 0; cyc <= g; cyc++) begin
            slv_ack = spur & ~one;
            if (!illegal && (cyc - 1 == dly)) slv_ack = slv_ack | one;
            if (wiggle && cyc >= 1) begin
                addr = $urandom; wdata = $urandom; we = ~we; hb = 2'($urandom);
            end
            #1;
            chk("wait_gnt", 32'(gnt), 32'(cyc == g));
            chk("wait_err", 32'(bus_err), 32'((cyc == g) && exp_err));
            if (cyc >= 1 && cyc < g) begin
                chk("wait_cs",    32'(slv_cs), 32'({4'b0000, lo}));
                chk("wait_addr",  slv_addr, a);
                chk("wait_wdata", slv_wdata, d);
                chk("wait_we_hb", 32'({slv_we, slv_hb}), 32'({w, h}));
            end else begin
                chk("wait_cs_idle", 32'(slv_cs), 32'h0);
            end
            if (cyc == g) begin
                chk("wait_rdata",    rdata, exp_rd);
                chk("wait_err_addr", err_addr, model_err_addr);
            end
            tick();
        end
    endtask

    typedef struct packed {
        logic        req;
        logic [7:0]  ce;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  hb;
        logic        exp_gnt;
        logic [7:0]  exp_cs;
        logic [31:0] exp_rdata;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{1'b0, 8'h20, 32'hDEADBEEF, 32'h00000001, 1'b1, 2'd3, 1'b1, 8'h00, 32'h00000000, 32'h00000000};
        tbl[1] = '{1'b1, 8'h20, 32'h00000020, 32'h0BADF00D, 1'b0, 2'd2, 1'b1, 8'h20, 32'h12345678, 32'h00000020};
        tbl[2] = '{1'b1, 8'h30, 32'h00000030, 32'h11112222, 1'b1, 2'd1, 1'b1, 8'h30, 32'h44444444, 32'h00000030};
        tbl[3] = '{1'b1, 8'hC0, 32'h000000C0, 32'h33334444, 1'b0, 2'd0, 1'b1, 8'hC0, 32'h66666666, 32'h000000C0};
        tbl[4] = '{1'b1, 8'h80, 32'h00000080, 32'h55556666, 1'b1, 2'd3, 1'b1, 8'h80, 32'h77777777, 32'h00000080};
        tbl[5] = '{1'b1, 8'h00, 32'h00000100, 32'h77778888, 1'b0, 2'd1, 1'b1, 8'h00, 32'h00000000, 32'h00000100};

        slots[0] = 32'hA5A5A5A5; slots[1] = 32'h11111111;
        slots[2] = 32'h22222222; slots[3] = 32'h33333333;
        slots[4] = 32'h44444444; slots[5] = 32'h12345678;
        slots[6] = 32'h66666666; slots[7] = 32'h77777777;
        model_err_addr = 32'h0;

        rst = 1'b1; req = 1'b0; ce = 8'h00; addr = 32'h0; wdata = 32'h0;
        we = 1'b0; hb = 2'd0; slv_ack = 8'h00;
        tick();
        tick();
        chk("rst_gnt",      32'(gnt), 32'h1);
        chk("rst_rdata",    rdata, 32'h0);
        chk("rst_cs",       32'(slv_cs), 32'h0);
        chk("rst_err",      32'(bus_err), 32'h0);
        chk("rst_err_addr", err_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Zero-wait table
        for (int i = 0; i < 6; i++) begin
            req = tbl[i].req; ce = tbl[i].ce; addr = tbl[i].addr;
            wdata = tbl[i].wdata; we = tbl[i].we; hb = tbl[i].hb; slv_ack = 8'h00;
            #1;
            chk("tbl_gnt",   32'(gnt), 32'(tbl[i].exp_gnt));
            chk("tbl_cs",    32'(slv_cs), 32'(tbl[i].exp_cs));
            chk("tbl_rdata", rdata, tbl[i].exp_rdata);
            chk("tbl_addr",  slv_addr, tbl[i].exp_addr);
            chk("tbl_wdata", slv_wdata, tbl[i].req ? tbl[i].wdata : 32'h0);
            chk("tbl_err",   32'(bus_err), 32'h0);
            tick();
        end

        // Wait read, ack on first access cycle
        run_wait(8'h01, 32'h00000100, 32'h0, 1'b0, 2'd2, 0, 1'b0, 8'h00);
        // Wait write, ack on third access cycle, core inputs change mid-access
        run_wait(8'h02, 32'h10000004, 32'hCAFEBABE, 1'b1, 2'd2, 2, 1'b1, 8'h00);
        // Timeout with a spurious ack from slave 0
        run_wait(8'h04, 32'h20000008, 32'h0, 1'b0, 2'd2, TIMEOUT, 1'b0, 8'h01);
        // Ack exactly on the last count: ack wins, no error
        run_wait(8'h08, 32'h2800000C, 32'h0, 1'b0, 2'd1, TIMEOUT - 1, 1'b0, 8'hF7);
        // Illegal multi-select
        run_wait(8'h03, 32'h3000000C, 32'h0, 1'b1, 2'd0, 0, 1'b0, 8'hFF);

        // Reset during an access
        req = 1'b1; ce = 8'h01; addr = 32'h40000000; slv_ack = 8'h00;
        #1;
        chk("rsta_gnt0", 32'(gnt), 32'h0);
        tick();
        chk("rsta_cs1", 32'(slv_cs), 32'h01);
        tick();
        rst = 1'b1;
        #1;
        chk("rsta_cs_drop",  32'(slv_cs), 32'h0);
        chk("rsta_gnt",      32'(gnt), 32'h0);
        chk("rsta_err",      32'(bus_err), 32'h0);
        chk("rsta_err_addr", err_addr, 32'h0);
        model_err_addr = 32'h0;
        tick();
        chk("rsta_hold_gnt", 32'(gnt), 32'h0);
        chk("rsta_hold_err", 32'(bus_err), 32'h0);
        rst = 1'b0; req = 1'b0;
        #1;
        chk("rsta_idle_gnt", 32'(gnt), 32'h1);
        chk("rsta_idle_cs",  32'(slv_cs), 32'h0);
        tick();
        run_wait(8'h01, 32'h40000004, 32'h12121212, 1'b1, 2'd3, 1, 1'b0, 8'h00);

        // Randomized transactions
        for (int t = 0; t < 120; t++) begin
            int kind;
            for (int n = 0; n < 8; n++) slots[n] = $urandom;
            kind = int'($urandom_range(0, 9));
            if (kind < 3) begin
                run_fast({4'($urandom), 4'b0000}, $urandom, $urandom, 1'($urandom), 2'($urandom));
            end else if (kind == 3) begin
                req = 1'b0; ce = 8'($urandom); addr = $urandom; slv_ack = 8'($urandom);
                #1;
                chk("idle_gnt",   32'(gnt), 32'h1);
                chk("idle_cs",    32'(slv_cs), 32'h0);
                chk("idle_rdata", rdata, 32'h0);
                chk("idle_addr",  slv_addr, 32'h0);
                tick();
            end else begin
                logic [3:0] lo;
                lo = 4'($urandom_range(1, 15));
                run_wait({4'($urandom), lo}, $urandom, $urandom, 1'($urandom), 2'($urandom),
                         int'($urandom_range(0, TIMEOUT + 1)), 1'($urandom), 8'($urandom));
            end
        end

        req = 1'b0; slv_ack = 8'h00;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
